bus_grant_sequencer: RTL
========================

// Module: bus_grant_sequencer
// PURPOSE
//  Queues bus-grant tokens from the bus arbiter (wr_en/fifo_data_in, 4-bit {type[1:0],id[1:0]})
//  and serialises them onto the shared common bus: one owner at a time, start pulse,
//  done handshake, timeout recovery. Sits between arbiter and bus datapath/cache controllers.
// PARAMETERS
//  DEPTH      8    token queue entries (power of 2, >=2)
//  TOKEN_W    4    token width {type,id}; type 01=proc, 10=snoop, 00/11=invalid
//  TIMEOUT    64   max GRANT cycles before forced release (>=2)
// PORTS
//  clk             in   1                   rising-edge clock
//  rst_n           in   1                   async active-low reset
//  wr_en           in   1                   push request from arbiter
//  fifo_data_in    in   TOKEN_W             token to push
//  bus_done        in   1                   owner finished transaction (1-cycle pulse)
//  full            out  1                   queue count == DEPTH
//  empty           out  1                   queue count == 0
//  count           out  $clog2(DEPTH)+1     entries held
//  overflow        out  1                   sticky: push attempted while full
//  bus_owner_valid out  1                   bus currently granted
//  bus_owner       out  TOKEN_W             token of current owner
//  bus_start       out  1                   1-cycle pulse, first GRANT cycle
//  timeout_err     out  1                   1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, rst_n=0): queue flushed (rd/wr ptr=0, count=0), state=IDLE, all outputs 0
//   except empty=1. Reset mid-GRANT drops ownership immediately; no release pulse.
//  Queue: circular, DEPTH entries, pointers wrap mod DEPTH. full/empty/count from registered count.
//   Push accepted iff wr_en && !full && type in {01,10}; invalid types silently dropped (no count
//   change, no overflow). wr_en && full -> token dropped, overflow<=1 (cleared only by reset).
//   Push while full is rejected even if a pop occurs same cycle. Push+pop same cycle: count unchanged.
//  FSM (IDLE, GRANT, RELEASE):
//   IDLE: if !empty -> pop head, bus_owner<=head, timer<=0, bus_start<=1, state<=GRANT.
//   GRANT: bus_owner_valid=1; bus_start high first cycle only; timer increments each cycle.
//    bus_done ignored in the bus_start cycle. Else bus_done=1 -> RELEASE.
//    Else timer==TIMEOUT-1 -> timeout_err pulse (1 cycle), RELEASE. bus_done wins same cycle.
//   RELEASE: bus_owner_valid=0, bus_owner held (debug), 1 cycle -> IDLE.
//  Latency: token pushed at edge N visible (count) after N; IDLE pops at N+1; bus_start and
//   bus_owner_valid high after edge N+1. Back-to-back grants: done at G -> RELEASE, IDLE, next GRANT.
//  Strict FIFO order; no priority reordering between proc/snoop tokens (arbiter already ordered).
//  bus_done outside GRANT ignored. All outputs registered except full/empty/count decode.
// TESTING
//  1 Reset: rst_n=0 mid-GRANT with 3 queued -> count=0, empty=1, bus_owner_valid=0, overflow=0.
//  2 Single proc: push 4'b0110, bus_done 3 cycles after bus_start -> bus_owner=4'b0110,
//    bus_start 1 cycle, valid 3 cycles, then RELEASE, IDLE, empty=1.
//  3 Ordering: push 0101,1000,0111 back-to-back -> granted in that order, 3 bus_start pulses.
//  4 Full/overflow: DEPTH=8, hold GRANT, push 9 valid tokens -> full=1, count=8, overflow=1,
//    9th token never granted; pointer wrap verified over 20 push/pop cycles.
//  5 Timeout: TIMEOUT=64, no bus_done -> timeout_err pulse at GRANT cycle 64, next token granted.
//  6 Edge cases: invalid token 4'b0000/4'b1100 -> count unchanged; bus_done with bus_start -> ignored;
//    bus_done + timeout same cycle -> no timeout_err; push+pop same cycle -> count steady.

Source files
------------

// File: rtl/bus_grant_sequencer.sv
// rtl/bus_grant_sequencer.sv - queues arbiter grant tokens and serialises bus ownership
module bus_grant_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TOKEN_W = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [TOKEN_W-1:0]       fifo_data_in,
    input  logic                     bus_done,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     bus_owner_valid,
    output logic [TOKEN_W-1:0]       bus_owner,
    output logic                     bus_start,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t               state;
    logic [TOKEN_W-1:0]   mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic [TW-1:0]        timer;
    logic [1:0]           tok_type;
    logic                 tok_valid;
    logic                 push;
    logic                 pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign tok_type  = fifo_data_in[TOKEN_W-1 -: 2];
    assign tok_valid = (tok_type == 2'b01) || (tok_type == 2'b10);
    // full is the registered view, so a pop in the same cycle never frees room for a push
    assign push      = wr_en && !full && tok_valid;
    assign pop       = (state == S_IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= fifo_data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
            if (wr_en && full && tok_valid)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bus_owner       <= '0;
            bus_owner_valid <= 1'b0;
            bus_start       <= 1'b0;
            timeout_err     <= 1'b0;
            timer           <= '0;
        end else begin
            bus_start   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        bus_owner       <= mem[rd_ptr];
                        bus_owner_valid <= 1'b1;
                        bus_start       <= 1'b1;
                        timer           <= '0;
                        state           <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    timer <= timer + TW'(1);
                    // done is not accepted in the start cycle; done beats a coincident timeout
                    if (!bus_start && bus_done) begin
                        bus_owner_valid <= 1'b0;
                        state           <= S_RELEASE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        bus_owner_valid <= 1'b0;
                        timeout_err     <= 1'b1;
                        state           <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    bus_owner_valid <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end
endmodule
